// File: rtl/load_store_unit.sv
// ============================================================================
// Module   : load_store_unit
// Function : Memory-access stage for loads and stores. It steers store byte
//            lanes, sign- or zero-extends load data, and reports misaligned,
//            illegal and timed-out accesses.
// Revision : 1.0
// ============================================================================
`default_nettype none

module load_store_unit #(
    parameter int TIMEOUT    = 15,
    parameter bit RD_ZERO_WB = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        is_store,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] store_data,
    input  logic [4:0]  rd,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic        wb_en,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic        busy,
    output logic        done,
    output logic        err
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WB   = 2'd2,
        S_FIN  = 2'd3
    } state_t;

    localparam logic [7:0] c_timeout = 8'(TIMEOUT);

    state_t      r_state;
    logic        r_is_store;
    logic [2:0]  r_funct3;
    logic [1:0]  r_lane;
    logic [4:0]  r_rd;
    logic [7:0]  r_cnt;

    logic        w_cmd_bad;
    logic [31:0] w_wdata;
    logic [3:0]  w_wstrb;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_ld_data;
    logic [7:0]  w_cnt_next;
    logic        w_wb_allow;

    // Command screening and store lane steering, from the live inputs at start
    always_comb begin
        w_cmd_bad = (funct3 == 3'b011) || (funct3[2:1] == 2'b11)
                 || (is_store && funct3[2])
                 || ((funct3[1:0] == 2'b01) && addr[0])
                 || ((funct3[1:0] == 2'b10) && (addr[1:0] != 2'b00));
        case (funct3[1:0])
            2'b00: begin
                w_wdata = {4{store_data[7:0]}};
                w_wstrb = 4'b0001 << addr[1:0];
            end
            2'b01: begin
                w_wdata = {2{store_data[15:0]}};
                w_wstrb = 4'b0011 << addr[1:0];
            end
            default: begin
                w_wdata = store_data;
                w_wstrb = 4'b1111;
            end
        endcase
        if (!is_store) begin
            w_wstrb = 4'b0000;
        end
    end

    always_comb begin
        w_byte = mem_rdata[{r_lane, 3'b000} +: 8];
        w_half = r_lane[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (r_funct3)
            3'b000:  w_ld_data = {{24{w_byte[7]}}, w_byte};
            3'b100:  w_ld_data = {24'h0, w_byte};
            3'b001:  w_ld_data = {{16{w_half[15]}}, w_half};
            3'b101:  w_ld_data = {16'h0, w_half};
            default: w_ld_data = mem_rdata;
        endcase
        w_cnt_next = r_cnt + 8'd1;
        w_wb_allow = RD_ZERO_WB || (r_rd != 5'd0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_is_store <= 1'b0;
            r_funct3   <= 3'b000;
            r_lane     <= 2'b00;
            r_rd       <= 5'd0;
            r_cnt      <= 8'd0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= 32'h0;
            mem_wdata  <= 32'h0;
            mem_wstrb  <= 4'b0000;
            wb_en      <= 1'b0;
            wb_rd      <= 5'd0;
            wb_data    <= 32'h0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_is_store <= is_store;
                        r_funct3   <= funct3;
                        r_lane     <= addr[1:0];
                        r_rd       <= rd;
                        busy       <= 1'b1;
                        if (w_cmd_bad) begin
                            r_state <= S_FIN;
                            done    <= 1'b1;
                            err     <= 1'b1;
                        end else begin
                            r_state   <= S_REQ;
                            r_cnt     <= 8'd0;
                            mem_req   <= 1'b1;
                            mem_we    <= is_store;
                            mem_addr  <= {addr[31:2], 2'b00};
                            mem_wdata <= w_wdata;
                            mem_wstrb <= w_wstrb;
                        end
                    end
                end
                S_REQ: begin
                    // An ack on the final allowed cycle wins over the timeout
                    if (mem_ack) begin
                        mem_req   <= 1'b0;
                        mem_we    <= 1'b0;
                        mem_wstrb <= 4'b0000;
                        if (r_is_store) begin
                            r_state <= S_FIN;
                            done    <= 1'b1;
                            err     <= 1'b0;
                        end else begin
                            r_state <= S_WB;
                            wb_en   <= w_wb_allow;
                            wb_rd   <= r_rd;
                            wb_data <= w_ld_data;
                        end
                    end else if (w_cnt_next == c_timeout) begin
                        r_cnt     <= w_cnt_next;
                        mem_req   <= 1'b0;
                        mem_we    <= 1'b0;
                        mem_wstrb <= 4'b0000;
                        r_state   <= S_FIN;
                        done      <= 1'b1;
                        err       <= 1'b1;
                    end else begin
                        r_cnt <= w_cnt_next;
                    end
                end
                S_WB: begin
                    wb_en   <= 1'b0;
                    r_state <= S_FIN;
                    done    <= 1'b1;
                    err     <= 1'b0;
                end
                default: begin
                    done    <= 1'b0;
                    err     <= 1'b0;
                    busy    <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
Memory-access stage between execute and the register file write port. Accepts one load or store per command and drives a data-memory request/acknowledge handshake. Performs byte-lane steering for stores and byte/half extraction with sign or zero extension for loads. Returns load results as a one-cycle write-back pulse to the register file, and flags misaligned accesses and memory timeouts.

Parameters:
TIMEOUT, 15, max cycles mem_req may stay high without mem_ack before error abort (1..255)
RD_ZERO_WB, 0, 1 = allow write-back to x0; 0 = suppress wb_en when rd==0

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  synchronous active-high reset
start  in  1  command valid; accepted only when busy==0
is_store  in  1  1 = store, 0 = load (sampled with start)
funct3  in  3  RISC-V width code: 000 B, 001 H, 010 W, 100 BU, 101 HU (store uses 000/001/010 only)
addr  in  32  byte address from execute
store_data  in  32  rs2 value for stores
rd  in  5  destination register for loads
mem_req  out  1  memory request, held until mem_ack or timeout
mem_we  out  1  1 = write cycle
mem_addr  out  32  word-aligned address (addr with [1:0]=0)
mem_wdata  out  32  store data replicated into lanes
mem_wstrb  out  4  byte-lane write strobes
mem_rdata  in  32  read data, valid when mem_ack=1
mem_ack  in  1  one-cycle acknowledge
wb_en  out  1  register-file write enable pulse
wb_rd  out  5  write-back register number
wb_data  out  32  write-back value
busy  out  1  command in progress
done  out  1  one-cycle completion pulse
err  out  1  valid with done; 1 = misaligned, illegal funct3, or timeout

Behaviour:
- Reset: every output 0, FSM to IDLE, timeout counter 0. rst mid-transaction aborts it immediately. No done or wb_en pulse is produced for the aborted command.
- States: IDLE, REQ, WB, FIN.
- IDLE:
  - On start, latch is_store, funct3, addr, store_data, rd.
  - Legal command: go to REQ and set busy=1 in the next cycle.
  - Misaligned (H with addr[0]=1; W with addr[1:0]!=0) or illegal funct3 (011, 110, 111; or a store with funct3 bit2=1): go to FIN with err=1. No memory access.
- REQ:
  - mem_req=1. mem_addr, mem_we, mem_wdata and mem_wstrb are stable the whole time mem_req is high.
  - Store lanes:
    - B: wdata = {4{data[7:0]}}, wstrb = 0001 << addr[1:0].
    - H: wdata = {2{data[15:0]}}, wstrb = 0011 << addr[1:0].
    - W: wdata = data, wstrb = 1111.
  - Loads drive wstrb = 0000.
  - mem_ack=1:
    - Drop mem_req the next cycle.
    - Load: capture mem_rdata and go to WB.
    - Store: go to FIN.
  - Timeout counter increments each REQ cycle without ack. When it reaches TIMEOUT, go to FIN with err=1 and drop mem_req.
  - An ack arriving in the same cycle the counter reaches TIMEOUT counts as success; ack has priority.
  - A mem_ack while not in REQ is ignored.
- WB (loads only, exactly one cycle):
  - wb_en=1 and wb_rd = latched rd.
  - wb_data is taken from the lane selected by addr[1:0]:
    - B/H: sign-extend.
    - BU/HU: zero-extend.
    - W: passthrough.
  - wb_en is forced 0 when rd==0 and RD_ZERO_WB==0; wb_data is still driven.
  - Go to FIN.
- FIN: done=1 for one cycle with err, then go to IDLE and clear busy.
- Latency, ack in the first REQ cycle:
  - Load: done 3 cycles after start.
  - Store: done 2 cycles after start.
  - Illegal command: done 1 cycle after start.
- A start asserted while busy=1 is ignored. Upstream must hold off.
- wb_en never coincides with err=1.

Test Plan:
- LB, addr=0x0000_1003, mem_rdata=0x80FF_1234, ack in first REQ cycle -> wb_en pulse, wb_data=0xFFFF_FF80, wb_rd=rd, done 3 cycles after start, err=0.
- LHU, addr=0x102, mem_rdata=0xBEEF_0000 -> wb_data=0x0000_BEEF. The same access with LH -> wb_data=0xFFFF_BEEF.
- SB, addr=0x201, store_data=0x0000_00AA -> mem_wdata=0xAAAA_AAAA, mem_wstrb=0010, mem_addr=0x200, mem_we=1, done 2 cycles after start, no wb_en.
- LW, addr=0x102 -> mem_req never asserted, done+err after 1 cycle. SW with funct3=100 -> same response.
- LW with mem_ack held low, TIMEOUT=15 -> mem_req high exactly 15 cycles, then done+err, no wb_en. Repeat with ack in cycle 15 -> success.
- LW with rd=0 -> no wb_en, done=1. rst asserted during REQ -> mem_req=0 next cycle, no done; a new start is then accepted normally.
